ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. It sits between ID and MEM.
- Holds the ID→EX pipeline register and computes ALU results and the load/store address.
- Drives the data SRAM request, so read data arrives for MEM in the following cycle.
- Contains the HI/LO registers and a 32-iteration shift-subtract divider for DIV/DIVU, which stalls the pipeline through the stall controller.

Parameters:
- DIV_ITER, 32, number of divider iterations (equals operand width).
- STALL_W, 6, width of the stall bus.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, synchronous, active-low (0 = reset, sampled on posedge clk).
- stall  in  STALL_W  stall bus; bit2 controls the ID→EX register, bit3 the EX→MEM register.
- id_valid  in  1  instruction from ID is valid.
- id_pc  in  32  instruction PC.
- id_alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI; others give 0.
- id_src1  in  32  operand A (shift amount for shifts, zero-extended).
- id_src2  in  32  operand B.
- id_div_op  in  2  00 none, 01 DIV, 10 DIVU, 11 treated as none.
- id_hilo_rd  in  2  00 ALU result, 01 MFLO, 10 MFHI.
- id_mem_en  in  1  load/store.
- id_mem_we  in  1  store (valid only with id_mem_en).
- id_store_data  in  32  rt value for SW.
- id_rf_we  in  1  register write.
- id_rf_waddr  in  5  destination register.
- ex_pc  out  32  registered PC.
- ex_rf_we  out  1  = registered rf_we & valid.
- ex_rf_waddr  out  5  destination register.
- ex_result  out  32  ALU, HI or LO result; equals the address for loads/stores.
- ex_is_load  out  1  valid & mem_en & ~mem_we.
- data_sram_en  out  1  valid & mem_en.
- data_sram_wen  out  4  4'b1111 when valid & mem_en & mem_we, else 0.
- data_sram_addr  out  32  src1+src2.
- data_sram_wdata  out  32  registered store data.
- stallreq_for_ex  out  1  stall request to the stall controller.

Behaviour:
- **ID→EX register**, on posedge clk, in priority order:
  - rst=0 → clear to all zero (valid=0).
  - Otherwise stall[2]=Stop & stall[3]=NoStop → clear (bubble).
  - Otherwise stall[2]=NoStop → load the id_* inputs.
  - Otherwise hold.
- **Outputs at reset:** all outputs 0; HI=LO=0; divider FSM in IDLE.
- **ALU (combinational from the register):**
  - ADD/SUB wrap modulo 2^32, no overflow trap.
  - SLT is signed and SLTU unsigned; both give 0/1.
  - Shifts use src1[4:0] on src2.
  - LUI = {src2[15:0],16'b0}.
- **SRAM request:** issued combinationally in the cycle the instruction is in EX. No alignment check; word access only.
- **Divider FSM** (IDLE, RUN, DONE):
  - IDLE, valid & div_op≠0:
    - stallreq=1.
    - Latch |dividend| and |divisor| (raw values for DIVU) and the sign flags.
    - Counter←0; next state RUN.
  - RUN:
    - stallreq=1.
    - One restoring step per cycle.
    - Counter increments; after DIV_ITER steps (counter=DIV_ITER-1) go to DONE.
  - DONE:
    - stallreq=0.
    - HI/LO written on the posedge ending DONE; next state IDLE.
    - The controller then releases the stall and the next instruction enters.
  - Total EX occupancy for a divide: 1+DIV_ITER+1 = 34 cycles. stallreq is high for 33 of them.
  - The divider must not restart on the same held instruction after DONE: a done flag is cleared when the ID→EX register loads.
- **Sign and boundary rules for the divider:**
  - Quotient is negated iff the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend.
  - Divisor 0: LO=0xFFFFFFFF and HI=dividend (raw), for both DIV and DIVU; no sign fixup.
  - 0x80000000 / -1 (DIV): LO=0x80000000, HI=0.
- **HI/LO visibility:** MFHI/MFLO in EX read the registered HI/LO. A MF* instruction immediately after a divide sees the new values because the write completes before it enters EX.
- **Reset mid-divide** (rst=0 in RUN/DONE): FSM→IDLE, stallreq=0, HI/LO=0. Partial results are discarded.
- **During a divide stall:** ex_rf_we=0 and data_sram_en=0, because a divide carries rf_we=0 and mem_en=0; the EX→MEM bubble is inserted by MEM's own register.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if divisor==0 or |dividend|<|divisor|, go directly to DONE, giving 2-cycle occupancy with stallreq high 1 cycle.
  - Results: divisor 0 → same values as above; small dividend → LO=0, HI=dividend.
- Undefined: always full 34-cycle iteration. Results are identical either way.

Test Plan:
- ADD src1=0x7FFFFFFF, src2=1 → ex_result=0x80000000; SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0.
- SW src1=0x100, src2=8, store_data=0xDEADBEEF → data_sram_en=1, wen=4'b1111, addr=0x108, wdata=0xDEADBEEF in the same cycle; LW → wen=0, ex_is_load=1.
- DIV -7/2 followed by MFLO then MFHI → stallreq high 33 cycles; MFLO result 0xFFFFFFFD (-3); MFHI result 0xFFFFFFFF (-1).
- DIVU 0x80000000/0 → LO=0xFFFFFFFF, HI=0x80000000; with DIV_EARLY_OUT_EN the stall lasts 1 cycle, otherwise 33.
- rst=0 asserted at RUN counter=10 → next cycle stallreq=0, HI=LO=0; a subsequent DIVU 100/7 gives LO=14, HI=2.
- stall[2]=Stop, stall[3]=NoStop with a valid ADD presented → EX register cleared: ex_rf_we=0, data_sram_en=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ID->EX pipeline register, ALU, data SRAM request, HI/LO and a restoring divider.
// Optional: define DIV_EARLY_OUT_EN to skip iteration for zero divisors and dividends smaller than the divisor.
module ex_stage #(
    parameter int DIV_ITER = 32,
    parameter int STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               id_valid,
    input  logic [31:0]        id_pc,
    input  logic [3:0]         id_alu_op,
    input  logic [31:0]        id_src1,
    input  logic [31:0]        id_src2,
    input  logic [1:0]         id_div_op,
    input  logic [1:0]         id_hilo_rd,
    input  logic               id_mem_en,
    input  logic               id_mem_we,
    input  logic [31:0]        id_store_data,
    input  logic               id_rf_we,
    input  logic [4:0]         id_rf_waddr,
    output logic [31:0]        ex_pc,
    output logic               ex_rf_we,
    output logic [4:0]         ex_rf_waddr,
    output logic [31:0]        ex_result,
    output logic               ex_is_load,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_wen,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata,
    output logic               stallreq_for_ex
);
    localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [3:0]  r_alu_op;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [1:0]  r_div_op;
    logic [1:0]  r_hilo_rd;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [31:0] r_store_data;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;

    div_state_t  r_div_state;
    logic [CNT_W-1:0] r_div_cnt;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_dsor;
    logic [31:0] r_dend_raw;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dsor_zero;
    logic        r_div_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_id_ex_update;
    logic [31:0] w_addr;
    logic [31:0] w_alu;
    logic [4:0]  w_shamt;
    logic        w_div_signed;
    logic        w_div_start;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic        w_early_out;
    logic        w_unused_stall;

    // Stop=1 on the stall bus; bit2 alone stopping means EX takes a bubble.
    always_ff @(posedge clk) begin
        if (!rst || (stall[2] && !stall[3])) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_alu_op     <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_div_op     <= '0;
            r_hilo_rd    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_store_data <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
        end else if (!stall[2]) begin
            r_valid      <= id_valid;
            r_pc         <= id_pc;
            r_alu_op     <= id_alu_op;
            r_src1       <= id_src1;
            r_src2       <= id_src2;
            r_div_op     <= id_div_op;
            r_hilo_rd    <= id_hilo_rd;
            r_mem_en     <= id_mem_en;
            r_mem_we     <= id_mem_we;
            r_store_data <= id_store_data;
            r_rf_we      <= id_rf_we;
            r_rf_waddr   <= id_rf_waddr;
        end
    end

    assign w_id_ex_update = !stall[2] || !stall[3];
    assign w_unused_stall = ^{stall[STALL_W-1:4], stall[1:0]};

    assign w_shamt = r_src1[4:0];
    assign w_addr  = r_src1 + r_src2;

    always_comb begin
        w_alu = 32'd0;
        case (r_alu_op)
            4'd0:  w_alu = r_src1 + r_src2;
            4'd1:  w_alu = r_src1 - r_src2;
            4'd2:  w_alu = r_src1 & r_src2;
            4'd3:  w_alu = r_src1 | r_src2;
            4'd4:  w_alu = r_src1 ^ r_src2;
            4'd5:  w_alu = ~(r_src1 | r_src2);
            4'd6:  w_alu = {31'd0, $signed(r_src1) < $signed(r_src2)};
            4'd7:  w_alu = {31'd0, r_src1 < r_src2};
            4'd8:  w_alu = r_src2 << w_shamt;
            4'd9:  w_alu = r_src2 >> w_shamt;
            4'd10: w_alu = $unsigned($signed(r_src2) >>> w_shamt);
            4'd11: w_alu = {r_src2[15:0], 16'd0};
            default: w_alu = 32'd0;
        endcase
    end

    always_comb begin
        ex_result = w_alu;
        if (r_mem_en)
            ex_result = w_addr;
        else if (r_hilo_rd == 2'b01)
            ex_result = r_lo;
        else if (r_hilo_rd == 2'b10)
            ex_result = r_hi;
    end

    assign ex_pc           = r_pc;
    assign ex_rf_we        = r_rf_we & r_valid;
    assign ex_rf_waddr     = r_rf_waddr;
    assign ex_is_load      = r_valid & r_mem_en & ~r_mem_we;
    assign data_sram_en    = r_valid & r_mem_en;
    assign data_sram_addr  = w_addr;
    assign data_sram_wdata = r_store_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wen
            assign data_sram_wen[gi] = r_valid & r_mem_en & r_mem_we;
        end
    endgenerate

    // Divider datapath: operands reduced to magnitudes, sign fixed up when writing HI/LO.
    assign w_div_signed = (r_div_op == 2'b01);
    assign w_div_start  = (r_div_state == S_IDLE) && r_valid && !r_div_done &&
                          ((r_div_op == 2'b01) || (r_div_op == 2'b10));
    assign w_abs_a  = (w_div_signed && r_src1[31]) ? -r_src1 : r_src1;
    assign w_abs_b  = (w_div_signed && r_src2[31]) ? -r_src2 : r_src2;
    assign w_rem_sh = {r_rem, r_quot[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_dsor};
    assign w_ge     = !w_diff[32];
    assign w_q_fix  = r_neg_q ? -r_quot : r_quot;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

`ifdef DIV_EARLY_OUT_EN
    assign w_early_out = (r_src2 == 32'd0) || (w_abs_a < w_abs_b);
`else
    assign w_early_out = 1'b0;
`endif

    assign stallreq_for_ex = w_div_start || (r_div_state == S_RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div_state <= S_IDLE;
            r_div_cnt   <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dsor      <= '0;
            r_dend_raw  <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dsor_zero <= 1'b0;
            r_div_done  <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            case (r_div_state)
                S_IDLE: begin
                    if (w_div_start) begin
                        r_dsor      <= w_abs_b;
                        r_dend_raw  <= r_src1;
                        r_neg_q     <= w_div_signed && (r_src1[31] ^ r_src2[31]);
                        r_neg_r     <= w_div_signed && r_src1[31];
                        r_dsor_zero <= (r_src2 == 32'd0);
                        r_div_cnt   <= '0;
                        if (w_early_out) begin
                            r_quot      <= '0;
                            r_rem       <= w_abs_a;
                            r_div_state <= S_DONE;
                        end else begin
                            r_quot      <= w_abs_a;
                            r_rem       <= '0;
                            r_div_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_quot    <= {r_quot[30:0], w_ge};
                    r_rem     <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
                    r_div_cnt <= r_div_cnt + CNT_W'(1);
                    if (r_div_cnt == CNT_W'(DIV_ITER - 1))
                        r_div_state <= S_DONE;
                end
                S_DONE: begin
                    if (r_dsor_zero) begin
                        r_lo <= 32'hFFFF_FFFF;
                        r_hi <= r_dend_raw;
                    end else begin
                        r_lo <= w_q_fix;
                        r_hi <= w_r_fix;
                    end
                    r_div_state <= S_IDLE;
                end
                default: r_div_state <= S_IDLE;
            endcase
            // The held divide must not restart once finished; a fresh load re-arms it.
            if (w_id_ex_update)
                r_div_done <= 1'b0;
            else if (r_div_state == S_DONE)
                r_div_done <= 1'b1;
        end
    end
endmodule
